// File: rtl/seg7_pkg.sv
// Shared constants and polarity helpers for the multiplexed 7-segment driver.
// Segment patterns are held internally in "lit = 0" form and only converted
// to the board polarity at the output registers.
package seg7_pkg;

  // Hex glyphs, {g,f,e,d,c,b,a}, a 0 bit lights the segment.
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // All eight segments (including dp) dark, in lit = 0 form.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Convert a lit = 0 cathode pattern to the board polarity.
  function automatic logic [7:0] seg_pol(input logic [7:0] seg_lo, input logic act_low);
    return act_low ? seg_lo : ~seg_lo;
  endfunction

  // Convert a lit = 1 anode select vector to the board polarity.
  function automatic logic [15:0] an_pol(input logic [15:0] sel_hi, input logic act_low);
    return act_low ? ~sel_hi : sel_hi;
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-segment decode with blanking and decimal point.
// Output is in lit = 0 form; polarity is applied by the caller.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp_on,
  output logic [7:0] seg_lo
);

  // Blank forces the seven digit segments dark; dp is handled independently.
  always_comb begin
    seg_lo = SEG_OFF;
    if (!blank) begin
      seg_lo[6:0] = GLYPH[nibble];
    end
    seg_lo[7] = ~dp_on;
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver.
// One digit is scanned per refresh slot. New values are taken through a
// shadow register and only applied at the frame boundary so a frame never
// shows a mix of old and new digits. The first BLANK_CYCLES of every slot
// keep all anodes off so the previous digit cannot ghost onto the next.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int SEG_ACT_LOW  = 1,
  parameter int AN_ACT_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic                    load,
  output logic [7:0]              cathode,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  localparam logic                  SEG_LOW   = (SEG_ACT_LOW != 0);
  localparam logic                  AN_LOW    = (AN_ACT_LOW != 0);
  localparam logic [7:0]            CATH_IDLE = SEG_LOW ? SEG_OFF : ~SEG_OFF;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE   = AN_LOW ? '1 : '0;

  // Scan position
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          slot_end;
  logic          frame_end;

  // Shadow (written by load) and display (used by the scan) copies
  logic [4*NUM_DIGITS-1:0] sh_value, disp_value;
  logic [NUM_DIGITS-1:0]   sh_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   sh_en, disp_en;
  logic                    sh_lz, disp_lz;
  logic                    pending;

  // Per-digit decode
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_above;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic                  cur_dp;
  logic [7:0]            cur_seg_lo;
  logic [15:0]           an_full;
  logic [7:0]            cath_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Slot counter and digit index; the index steps once per full slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture and frame-boundary transfer; a load on the boundary
  // cycle itself goes straight to the display for the frame starting next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_en      <= '0;
      sh_lz      <= 1'b0;
      pending    <= 1'b0;
      disp_value <= '0;
      disp_dp    <= '0;
      disp_en    <= '0;
      disp_lz    <= 1'b0;
    end else begin
      if (load) begin
        sh_value <= value;
        sh_dp    <= dp;
        sh_en    <= digit_en;
        sh_lz    <= lz_suppress;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          disp_value <= value;
          disp_dp    <= dp;
          disp_en    <= digit_en;
          disp_lz    <= lz_suppress;
        end else if (pending) begin
          disp_value <= sh_value;
          disp_dp    <= sh_dp;
          disp_en    <= sh_en;
          disp_lz    <= sh_lz;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Leading-zero mask: digit i blanks when it and every digit above it is
  // zero. Digit 0 is never masked so a zero value still shows "0".
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_value[4*i +: 4] == 4'h0);
      lz_mask[i] = disp_lz && zero_above;
    end
  end

  // Select the digit under scan; a disabled digit also loses its dp.
  always_comb begin
    cur_nib   = disp_value[idx*4 +: 4];
    cur_blank = !disp_en[idx] || lz_mask[idx];
    cur_dp    = disp_dp[idx] && disp_en[idx];
  end

  seg7_glyph u_glyph (
    .nibble (cur_nib),
    .blank  (cur_blank),
    .dp_on  (cur_dp),
    .seg_lo (cur_seg_lo)
  );

  // Next output values; anodes held off during the anti-ghost window while
  // the cathodes already carry the new digit.
  always_comb begin
    cath_next = seg_pol(cur_seg_lo, SEG_LOW);
    if (int'(cnt) < BLANK_CYCLES) begin
      an_full = an_pol(16'h0000, AN_LOW);
    end else begin
      an_full = an_pol(16'h0001 << idx, AN_LOW);
    end
    an_next = an_full[NUM_DIGITS-1:0];
  end

  // Registered pin drivers and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cathode    <= CATH_IDLE;
      anode      <= AN_IDLE;
      frame_done <= 1'b0;
    end else begin
      cathode    <= cath_next;
      anode      <= an_next;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Directed bench for seg7_mux_driver: 4 digits, 4-cycle slots, 1 blank cycle,
// active-low segments and anodes. One frame is 16 clocks.
module tb_seg7_mux_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        lz_suppress;
  logic        load;
  logic [7:0]  cathode;
  logic [3:0]  anode;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int k      = 0;     // posedges since last reset release
  bit chk_en = 1'b0;  // per-cycle scan checks active

  seg7_mux_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1),
    .SEG_ACT_LOW  (1),
    .AN_ACT_LOW   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp          (dp),
    .digit_en    (digit_en),
    .lz_suppress (lz_suppress),
    .load        (load),
    .cathode     (cathode),
    .anode       (anode),
    .frame_done  (frame_done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Never more than one digit driven at once.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("onehot", {15'b0, ($countones(~anode) <= 1)}, 16'd1);
    end
  end

  // Advance one clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    logic [3:0] ea;
    int s;
    @(posedge clk);
    #1;
    k++;
    if (chk_en) begin
      s = (k - 1) % 16;
      if (s % 4 == 0) ea = 4'hF;
      else            ea = ~(4'b0001 << (s / 4));
      chk("anode", {12'b0, anode}, {12'b0, ea});
      chk("frame_done", {15'b0, frame_done}, {15'b0, (k % 16 == 0)});
    end
  endtask

  task automatic goto_k(input int target);
    while (k < target) tick();
  endtask

  // Check all four cathode patterns of the frame following boundary 16*n.
  task automatic frame_check(input int n, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int d = 0; d < 4; d++) begin
      goto_k(16*n + 4*d + 1);
      chk($sformatf("cath_blankwin_f%0d_d%0d", n, d), {8'b0, cathode}, {8'b0, e[d]});
      goto_k(16*n + 4*d + 4);
      chk($sformatf("cath_f%0d_d%0d", n, d), {8'b0, cathode}, {8'b0, e[d]});
    end
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] p,
                            input logic [3:0] en, input logic lz);
    value       = v;
    dp          = p;
    digit_en    = en;
    lz_suppress = lz;
    load        = 1'b1;
    tick();
    load        = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    value       = '0;
    dp          = '0;
    digit_en    = '0;
    lz_suppress = 1'b0;
    load        = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", {12'b0, anode}, 16'h000F);
    chk("rst_cathode", {8'b0, cathode}, 16'h00FF);
    chk("rst_frame_done", {15'b0, frame_done}, 16'h0000);

    // Release: scan starts at digit 0, display all zero (digits disabled)
    rst_n  = 1'b1;
    k      = 0;
    chk_en = 1'b1;
    frame_check(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // Mid-frame load shows from the next frame on
    goto_k(18);
    drive_load(16'h12AF, 4'b0100, 4'hF, 1'b0);
    goto_k(22);
    chk("no_tear_f1", {8'b0, cathode}, 16'h00FF);
    frame_check(2, 8'h8E, 8'h88, 8'h24, 8'hF9);

    // Leading-zero suppression
    goto_k(50);
    drive_load(16'h0070, 4'b0000, 4'hF, 1'b1);
    frame_check(4, 8'hC0, 8'hF8, 8'hFF, 8'hFF);
    goto_k(82);
    drive_load(16'h0000, 4'b0000, 4'hF, 1'b1);
    frame_check(6, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

    // Two loads in one frame: current frame untouched, last one wins
    goto_k(113);
    drive_load(16'h1111, 4'b0000, 4'hF, 1'b0);
    goto_k(116);
    chk("tear_f7_d0", {8'b0, cathode}, 16'h00C0);
    goto_k(117);
    drive_load(16'h2222, 4'b0000, 4'hF, 1'b0);
    goto_k(127);
    chk("tear_f7_d3", {8'b0, cathode}, 16'h00FF);
    frame_check(8, 8'hA4, 8'hA4, 8'hA4, 8'hA4);

    // Load on the boundary cycle takes effect in the very next frame
    goto_k(159);
    drive_load(16'h3333, 4'b0000, 4'hF, 1'b0);
    frame_check(10, 8'hB0, 8'hB0, 8'hB0, 8'hB0);

    // Per-digit enable: disabled digits dark including dp
    goto_k(178);
    drive_load(16'h8888, 4'b1111, 4'b1010, 1'b0);
    frame_check(12, 8'hFF, 8'h00, 8'hFF, 8'h00);

    // Reset in the middle of digit 2's slot
    goto_k(218);
    chk("pre_rst_anode_d2", {12'b0, anode}, 16'h000B);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_anode", {12'b0, anode}, 16'h000F);
    chk("midrst_cathode", {8'b0, cathode}, 16'h00FF);
    chk("midrst_frame_done", {15'b0, frame_done}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold_anode", {12'b0, anode}, 16'h000F);
    chk("midrst_hold_cathode", {8'b0, cathode}, 16'h00FF);

    // Scan restarts at digit 0 with display cleared
    rst_n  = 1'b1;
    k      = 0;
    chk_en = 1'b1;
    frame_check(0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    goto_k(20);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
